pe_dispatch_seq: RTL

//  Upstream sequencer for pe_array_interface. Takes one vector-op command (base addrs A/B, length)

---
 rtl/instr_pkg.sv | 11 +
 rtl/nmcu_pkg.sv | 20 ++
 rtl/pe_dispatch_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Instruction word carried alongside a vector op; the dispatcher forwards it to
// the PE interface without interpreting any field.
package instr_pkg;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] dst;
        logic [7:0] imm;
    } instruction_t;

endpackage

// File: rtl/nmcu_pkg.sv
// Shared widths and the dispatch sequencer state encoding for the near-memory compute unit.
package nmcu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int LEN_WIDTH  = 4;
    localparam int ACC_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        ISSUE,
        WAIT_DONE,
        FINISH
    } dispatch_state_e;

endpackage

// File: rtl/pe_dispatch_seq.sv
// Vector-op sequencer: fetches A[i]/B[i] pairs from memory, hands each pair to the
// PE interface, and reduces the signed PE results into a single sum.
module pe_dispatch_seq
    import instr_pkg::*;
#(
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = nmcu_pkg::LEN_WIDTH,
    parameter int ACC_WIDTH  = nmcu_pkg::ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  instruction_t          cmd_instr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    output logic                  pe_cmd_valid_o,
    input  logic                  pe_cmd_ready_i,
    output instruction_t          pe_cmd_o,
    output logic [DATA_WIDTH-1:0] pe_operand_a_o,
    output logic [DATA_WIDTH-1:0] pe_operand_b_o,
    input  logic                  pe_done_i,
    input  logic [DATA_WIDTH-1:0] pe_result_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ACC_WIDTH-1:0]  acc_result_o
);
    import nmcu_pkg::*;

    dispatch_state_e       state_q, state_d;
    instruction_t          instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  res_q, res_d;

    logic [ACC_WIDTH-1:0]  result_ext;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic                  last_elem;

    assign result_ext = ACC_WIDTH'($signed(pe_result_i));
    assign acc_sum    = acc_q + result_ext;
    // idx only ever reaches len-1, so a full-scale len never wraps idx
    assign last_elem  = (idx_q == len_q - LEN_WIDTH'(1));

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        addr_a_d        = addr_a_q;
        addr_b_d        = addr_b_q;
        len_d           = len_q;
        idx_d           = idx_q;
        opa_d           = opa_q;
        opb_d           = opb_q;
        acc_d           = acc_q;
        res_d           = res_q;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        pe_cmd_valid_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    instr_d  = cmd_instr_i;
                    addr_a_d = cmd_addr_a_i;
                    addr_b_d = cmd_addr_b_i;
                    len_d    = cmd_len_i;
                    idx_d    = '0;
                    acc_d    = '0;
                    res_d    = '0;
                    state_d  = (cmd_len_i == '0) ? FINISH : REQ_A;
                end
            end
            REQ_A: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_a_q + ADDR_WIDTH'(idx_q);
                if (mem_req_ready_i) state_d = WAIT_A;
            end
            WAIT_A: begin
                if (mem_rsp_valid_i) begin
                    opa_d   = mem_rsp_data_i;
                    state_d = REQ_B;
                end
            end
            REQ_B: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_b_q + ADDR_WIDTH'(idx_q);
                if (mem_req_ready_i) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (mem_rsp_valid_i) begin
                    opb_d   = mem_rsp_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pe_cmd_valid_o = 1'b1;
                if (pe_cmd_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pe_done_i) begin
                    acc_d = acc_sum;
                    if (last_elem) begin
                        res_d   = acc_sum;
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + LEN_WIDTH'(1);
                        state_d = REQ_A;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
        end
    end

    assign cmd_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == FINISH);
    assign pe_cmd_o       = instr_q;
    assign pe_operand_a_o = opa_q;
    assign pe_operand_b_o = opb_q;
    assign acc_result_o   = res_q;

endmodule
